// File: rtl/counter_ud_param.sv
// Parametrised up/down counter with programmable step and bounds, wrap or
// saturate on a boundary event, clamped parallel load and sticky overflow.
module counter_ud_param #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             cfg_err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             bad_cfg;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             up_evt, dn_evt, evt;
    logic             count_ok;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] evt_val;

    assign bad_cfg = lo > hi;

    // Boundary detection. The sum is one bit wider so a carry out of WIDTH
    // bits still compares above hi; borrow catches a wrap below zero that
    // the truncated difference would otherwise hide.
    always_comb begin
        sum    = {1'b0, q_q} + {1'b0, step};
        diff   = q_q - step;
        borrow = q_q < step;
        up_evt = sum > {1'b0, hi};
        dn_evt = borrow || (diff < lo);
        evt    = ud ? up_evt : dn_evt;
    end

    // Load clamps into [lo,hi] only while the bounds are coherent.
    always_comb begin
        load_val = din;
        if (!bad_cfg) begin
            if (din < lo) begin
                load_val = lo;
            end else if (din > hi) begin
                load_val = hi;
            end
        end
    end

    // Wrap jumps to the opposite bound, saturate pins to the bound crossed.
    always_comb begin
        evt_val = lo;
        case ({mode, ud})
            2'b01:   evt_val = lo;
            2'b00:   evt_val = hi;
            2'b11:   evt_val = hi;
            default: evt_val = lo;
        endcase
    end

    assign count_ok = en && !bad_cfg && (step != '0);

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q && !clr_ovf;
        if (load) begin
            q_d = load_val;
        end else if (count_ok) begin
            if (evt) begin
                q_d   = evt_val;
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end else if (ud) begin
                q_d = sum[WIDTH-1:0];
            end else begin
                q_d = diff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q       = q_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign cfg_err = bad_cfg;

endmodule

// File: tb/tb_counter_ud_param.sv
// Bench for counter_ud_param: directed scenarios plus randomized traffic,
// all checked against an integer-arithmetic reference model.
module tb_counter_ud_param;

    localparam int             W  = 8;
    localparam logic [W-1:0]   RV = 8'h00;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, ud, mode, load, clr_ovf;
    logic [W-1:0] step, lo, hi, din;
    logic [W-1:0] q;
    logic         tc, ovf, cfg_err;

    int checks = 0;
    int errors = 0;

    int m_q;
    int m_tc;
    int m_ovf;

    counter_ud_param #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .ud(ud), .step(step),
        .lo(lo), .hi(hi), .mode(mode), .load(load), .din(din),
        .clr_ovf(clr_ovf), .q(q), .tc(tc), .ovf(ovf), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the behavioural rules.
    task automatic model_edge();
        int nxt;
        int evt;
        int l, h, s, d;
        l   = int'(lo);
        h   = int'(hi);
        s   = int'(step);
        d   = int'(din);
        evt = 0;
        nxt = m_q;
        if (load) begin
            if (l > h)      nxt = d;
            else if (d < l) nxt = l;
            else if (d > h) nxt = h;
            else            nxt = d;
        end else if (en && l <= h && s != 0) begin
            if (ud) begin
                if (m_q + s > h) begin
                    evt = 1;
                    nxt = mode ? h : l;
                end else begin
                    nxt = m_q + s;
                end
            end else begin
                if (m_q - s < l) begin
                    evt = 1;
                    nxt = mode ? l : h;
                end else begin
                    nxt = m_q - s;
                end
            end
        end
        m_q  = nxt;
        m_tc = evt;
        if (evt != 0)    m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".tc"}, 32'(tc), 32'(m_tc));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    task automatic set(input logic e, input logic u, input int s, input int l, input int h,
                       input logic m, input logic ld, input int di, input logic c);
        en = e; ud = u; step = W'(s); lo = W'(l); hi = W'(h);
        mode = m; load = ld; din = W'(di); clr_ovf = c;
    endtask

    int exp_q2 [5] = '{13, 16, 19, 20, 20};
    int exp_t2 [5] = '{0, 0, 0, 1, 1};

    initial begin
        reset = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_q = int'(RV); m_tc = 0; m_ovf = 0;
        #12;
        chk("rst.q", 32'(q), 32'(RV));
        chk("rst.tc", 32'(tc), 0);
        chk("rst.ovf", 32'(ovf), 0);
        chk("rst.cfg", 32'(cfg_err), 0);
        reset = 1'b0;

        // 1: full-range wrap
        set(1, 1, 1, 0, 255, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            cyc("t1");
            chk("t1.qd", 32'(q), 32'((i + 1) % 256));
            chk("t1.tcd", 32'(tc), (i == 255) ? 1 : 0);
        end
        chk("t1.ovfd", 32'(ovf), 1);

        // 2: saturate up, then step down
        set(1, 1, 3, 10, 20, 1, 1, 10, 0);
        cyc("t2ld");
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc("t2");
            chk("t2.qd", 32'(q), 32'(exp_q2[i]));
            chk("t2.tcd", 32'(tc), 32'(exp_t2[i]));
        end
        ud = 1'b0;
        cyc("t2dn");
        chk("t2dn.qd", 32'(q), 17);
        chk("t2dn.tcd", 32'(tc), 0);

        // 3: down wrap
        set(1, 0, 3, 10, 20, 0, 1, 12, 0);
        cyc("t3ld");
        load = 1'b0;
        cyc("t3a");
        chk("t3a.qd", 32'(q), 20);
        chk("t3a.tcd", 32'(tc), 1);
        cyc("t3b");
        chk("t3b.qd", 32'(q), 17);
        chk("t3b.tcd", 32'(tc), 0);

        // 4: load clamp beats enable
        set(1, 1, 1, 5, 20, 0, 1, 200, 0);
        cyc("t4a");
        chk("t4a.qd", 32'(q), 20);
        chk("t4a.tcd", 32'(tc), 0);
        din = W'(2);
        cyc("t4b");
        chk("t4b.qd", 32'(q), 5);

        // 5: clr_ovf vs event, then config error
        set(0, 1, 1, 5, 20, 0, 0, 0, 1);
        cyc("t5clr0");
        chk("t5clr0.ovfd", 32'(ovf), 0);
        set(1, 1, 100, 5, 20, 1, 0, 0, 1);
        cyc("t5ev");
        chk("t5ev.ovfd", 32'(ovf), 1);
        chk("t5ev.qd", 32'(q), 20);
        set(0, 1, 1, 5, 20, 1, 0, 0, 1);
        cyc("t5clr");
        chk("t5clr.ovfd", 32'(ovf), 0);
        set(1, 1, 1, 30, 20, 0, 0, 0, 0);
        #1;
        chk("t5.cfg", 32'(cfg_err), 1);
        cyc("t5hold");
        chk("t5hold.qd", 32'(q), 20);
        load = 1'b1; din = W'(40);
        cyc("t5ld");
        chk("t5ld.qd", 32'(q), 40);

        // 6: async reset mid-count
        set(1, 1, 255, 0, 255, 1, 0, 0, 0);
        cyc("t6ev");
        set(1, 1, 1, 0, 255, 0, 1, 8'h37, 0);
        cyc("t6ld");
        load = 1'b0;
        cyc("t6c");
        chk("t6c.qd", 32'(q), 8'h38);
        #2;
        reset = 1'b1;
        #1;
        m_q = int'(RV); m_tc = 0; m_ovf = 0;
        chk("t6r.q", 32'(q), 32'(RV));
        chk("t6r.tc", 32'(tc), 0);
        chk("t6r.ovf", 32'(ovf), 0);
        @(posedge clk);
        #1;
        chk("t6hold.q", 32'(q), 32'(RV));
        reset = 1'b0;
        cyc("t6res");
        chk("t6res.qd", 32'(q), 32'(RV) + 1);

        // 7: randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int l, h;
            l = $urandom_range(0, 255);
            h = $urandom_range(0, 255);
            if ($urandom_range(0, 9) != 0 && l > h) begin
                int t;
                t = l; l = h; h = t;
            end
            set($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4),
                l, h, $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 255), $urandom_range(0, 7) == 0);
            #1;
            chk("rnd.cfg", 32'(cfg_err), (l > h) ? 1 : 0);
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ud_param.md
Name: counter_ud_param

Overview:
- Parametrised up/down counter; next generation of the team's 8-bit CounterUD.
- Adds enable, programmable step, programmable lower/upper bounds, wrap or saturate mode, parallel load with clamping, terminal-count pulse, sticky overflow flag and config-error detect.
- Used as a general event/position counter in datapath and timer blocks.

Parameters:
- WIDTH, 8, counter/data width in bits (≥2).
- RESET_VAL, 0, value of q after reset. May lie outside [lo,hi].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- ud  input  1  direction: 1 = up, 0 = down.
- step  input  WIDTH  increment/decrement magnitude, unsigned.
- lo  input  WIDTH  lower bound, unsigned, inclusive.
- hi  input  WIDTH  upper bound, unsigned, inclusive.
- mode  input  1  0 = wrap, 1 = saturate.
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- clr_ovf  input  1  clears the sticky overflow flag.
- q  output  WIDTH  counter value, registered.
- tc  output  1  terminal-count pulse, registered.
- ovf  output  1  sticky boundary-event flag, registered.
- cfg_err  output  1  combinational; 1 when lo > hi.

Behaviour:
- Reset (async, immediate): q=RESET_VAL, tc=0, ovf=0. Reset asserted mid-count aborts the count with no tc.
- Update priority each rising edge: reset > load > (en & !cfg_err) > hold.
- Load: q <= din clamped to [lo,hi]: din<lo gives lo, din>hi gives hi. Load never sets tc or ovf.
- When lo>hi, load is unclamped: q <= din.
- Latency: all registered outputs change on the edge that samples the inputs. No pipeline.
- Up count: compute sum = q + step in WIDTH+1 bits.
  - sum ≤ hi: q <= sum, no event.
  - sum > hi: boundary event.
- Down count: no event when q ≥ step and q − step ≥ lo; then q <= q − step. Otherwise boundary event. Detect underflow below 0 explicitly.
- Boundary event, wrap mode: q <= lo when counting up, hi when counting down.
- Boundary event, saturate mode: q <= hi when counting up, lo when counting down.
- Any boundary event sets tc=1 for that cycle only and sets ovf=1.
- Exact landing on a bound (sum == hi, or difference == lo) is not an event.
- Saturate mode at a bound with en held: an event fires every enabled cycle, so tc stays high each such cycle and q holds the bound.
- step = 0: q holds, no event.
- If q is outside [lo,hi] (after reset or a bound change), the normal rules apply to the current q.
  - Example: up count with q > hi gives an event and goes to lo (wrap) or hi (sat).
- tc = 0 in every cycle without an event, including load, hold and disabled cycles.
- ovf: set by an event; cleared by clr_ovf. An event and clr_ovf in the same cycle leave ovf = 1.
- cfg_err: combinational (lo > hi). While it is 1, counting is suppressed and q holds unless load is asserted.
- ud, step, lo, hi and mode are sampled every enabled edge; changing them mid-count takes effect on the next edge.

Test Plan:
1. Wrap wrap-around: reset, lo=0, hi=255, step=1, mode=0, ud=1, en=1, 256 edges.
   - q goes 0..255 then 0.
   - tc high only on the edge where q returns to 0.
   - ovf becomes 1 and stays 1.
2. Saturate: lo=10, hi=20, step=3, mode=1, load din=10, then count up.
   - q = 13, 16, 19, 20, 20...
   - tc=1 from the edge giving 20 onward.
   - Then ud=0: q = 17 with tc=0.
3. Down wrap: lo=10, hi=20, step=3, mode=0, load 12, ud=0.
   - One edge gives q=20 with tc=1.
   - Next edge gives q=17 with tc=0.
4. Load clamp and priority: hi=20, lo=5.
   - load din=200 with en=1 gives q=20, tc=0.
   - load din=2 gives q=5.
5. Overflow clear and config error:
   - clr_ovf coincident with an event keeps ovf=1; clr_ovf alone clears it next edge.
   - lo=30, hi=20 gives cfg_err=1; q holds under en, and load din=40 gives q=40.
6. Async reset mid-count: q=0x37 counting up; assert reset between edges.
   - q=RESET_VAL immediately; tc=0, ovf=0.
   - Counting resumes one edge after reset deasserts.
